m_cache_refill: RTL and testbench
=================================

Name: m_cache_refill

Overview:
Refill and flush controller paired with the 32-entry direct-mapped instruction cache. The cache line format is {valid, tag[24:0], data[31:0]}, indexed by adr[6:2].
- Watches the fetch address and the cache hit flag, and stalls the fetch stage on a miss.
- Fetches the missing word from main memory over a req/ack handshake, then writes the completed line into the cache write port.
- Also provides a 32-cycle invalidate-all walk and saturating hit/miss counters.

Parameters:
CW, 32, width of the hit and miss performance counters (min 4).

Ports:
w_clk  in  1  clock; all state updates on posedge.
w_rst  in  1  synchronous reset, active-high.
w_adr  in  32  fetch address, same value presented to the cache read port.
w_fetch  in  1  fetch valid this cycle.
w_hit  in  1  cache hit flag for w_adr.
w_flush  in  1  invalidate-all request (level; sampled each cycle).
w_stall  out  1  fetch stage must hold w_adr and ignore cache data.
w_mem_req  out  1  memory read request.
w_mem_adr  out  32  word-aligned memory address.
w_mem_ack  in  1  one-cycle pulse; w_mem_rdata valid in the same cycle.
w_mem_rdata  in  32  memory read data.
w_cwe  out  1  cache write enable.
w_cwadr  out  5  cache write index.
w_cwd  out  58  cache write line.
w_nhit  out  CW  hit counter.
w_nmiss  out  CW  miss counter.

Behaviour:
- Reset: all of the following are cleared on the first posedge with w_rst=1, regardless of state.
  - State goes to IDLE; r_adr, r_data and the flush index are 0; the pending-flush flag is cleared.
  - Counters are 0; w_mem_req, w_cwe and w_stall are 0 from the following cycle.
  - Cache contents are not touched; software issues w_flush after reset.
- States and transitions:
  - IDLE.
    - If w_flush=1 (or a flush is pending): go to FLUSH with index 0.
    - Else if w_fetch & ~w_hit: latch r_adr<=w_adr, increment the miss counter, go to MISS.
    - Else if w_fetch & w_hit: increment the hit counter.
    - Flush has priority over a simultaneous miss. The miss is re-detected after the flush, because the line is then invalid.
  - MISS.
    - w_mem_req=1 and w_mem_adr={r_adr[31:2],2'b00}, both held stable until w_mem_ack.
    - On w_mem_ack: r_data<=w_mem_rdata, go to FILL.
    - An ack in the first MISS cycle is legal (zero-wait memory). w_mem_ack in any other state is ignored.
  - FILL, exactly one cycle.
    - w_cwe=1, w_cwadr=r_adr[6:2], w_cwd={1'b1, r_adr[31:7], r_data}.
    - Then go to FLUSH if a flush is pending, else to IDLE.
  - FLUSH.
    - Each cycle: w_cwe=1, w_cwadr=index, w_cwd=58'b0; index increments.
    - After writing index 31, go to IDLE and clear the pending flag.
    - Takes exactly 32 cycles; w_flush during FLUSH is ignored (no re-arm).
- w_flush asserted while in MISS or FILL sets the pending flag. The flush runs immediately after FILL; the in-flight refill always completes first.
- w_stall = (state!=IDLE) | (state==IDLE & ((w_fetch & ~w_hit) | w_flush | pending)).
  - The combinational term means the cycle in which a miss is detected is already stalled.
- Miss latency: with an ack k cycles after MISS entry (k≥0), the sequence is detect, MISS (k+1 cycles), FILL (1 cycle), then IDLE. In IDLE the cache now hits on the same w_adr, so w_stall=0.
- w_cwe=0 in IDLE and MISS. w_mem_req=0 outside MISS.
- Counters: saturating at all-ones, never wrapping. Hits are counted only in IDLE with w_stall=0, so the post-refill hit counts once.

Test Plan:
- Cold miss:
  - Stimulus: reset, then w_fetch=1, w_adr=0x0000_0084, w_hit=0; ack 3 cycles after req with rdata=0xDEAD_BEEF.
  - Response: w_mem_adr=0x0000_0084 held 4 cycles; FILL writes w_cwadr=1, w_cwd={1,25'h000001,0xDEADBEEF}; w_nmiss=1.
  - After the fill, w_hit=1 drives w_stall=0 and w_nhit=1.
- Zero-wait memory: ack in the first MISS cycle -> w_stall high for exactly 3 cycles (detect, MISS, FILL).
- Flush walk: w_flush pulsed in IDLE -> w_cwe=1 for 32 consecutive cycles with w_cwadr 0..31 and w_cwd=0; w_stall high for 32 cycles plus the request cycle.
- Flush during miss: w_flush pulsed mid-MISS -> the refill write occurs first, then the 32-cycle flush, then IDLE; the refilled line is left invalid.
- Reset mid-MISS: w_rst with w_mem_req=1 -> next cycle w_mem_req=0, w_cwe=0, counters 0; a late ack is ignored with no cache write.
- Saturation: CW=4, 20 hits -> w_nhit stays at 15; 20 misses -> w_nmiss=15.

Source files
------------

// File: rtl/m_cache_refill.sv
`default_nettype none
// ============================================================================
// m_cache_refill : refill / invalidate-all controller for a 32-entry I-cache
// Rev 1.0
// ============================================================================
module m_cache_refill #(
    parameter int CW = 32
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic [31:0]   w_adr,
    input  logic          w_fetch,
    input  logic          w_hit,
    input  logic          w_flush,
    output logic          w_stall,
    output logic          w_mem_req,
    output logic [31:0]   w_mem_adr,
    input  logic          w_mem_ack,
    input  logic [31:0]   w_mem_rdata,
    output logic          w_cwe,
    output logic [4:0]    w_cwadr,
    output logic [57:0]   w_cwd,
    output logic [CW-1:0] w_nhit,
    output logic [CW-1:0] w_nmiss
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_FILL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [31:0]   adr_q;
    logic [31:0]   data_q;
    logic [4:0]    idx_q;
    logic          pend_q;
    logic [CW-1:0] nhit_q, nhit_d;
    logic [CW-1:0] nmiss_q, nmiss_d;

    logic w_is_idle, w_flush_go, w_miss_det, w_hit_cnt, w_miss_cnt;
    logic w_unused;

    assign w_is_idle  = (state_q == S_IDLE);
    assign w_flush_go = w_flush | pend_q;
    assign w_miss_det = w_fetch & ~w_hit;

    // The detect cycle is already stalled through the combinational term.
    assign w_stall    = ~w_is_idle | w_miss_det | w_flush_go;
    assign w_hit_cnt  = w_is_idle & ~w_stall & w_fetch & w_hit;
    assign w_miss_cnt = w_is_idle & ~w_flush_go & w_miss_det;

    assign nhit_d  = (w_hit_cnt  && (nhit_q  != '1)) ? nhit_q  + C_ONE : nhit_q;
    assign nmiss_d = (w_miss_cnt && (nmiss_q != '1)) ? nmiss_q + C_ONE : nmiss_q;

    assign w_mem_req = (state_q == S_MISS);
    assign w_mem_adr = {adr_q[31:2], 2'b00};
    assign w_cwe     = (state_q == S_FILL) | (state_q == S_FLUSH);
    assign w_cwadr   = (state_q == S_FLUSH) ? idx_q : adr_q[6:2];
    assign w_cwd     = (state_q == S_FLUSH) ? 58'd0 : {1'b1, adr_q[31:7], data_q};
    assign w_nhit    = nhit_q;
    assign w_nmiss   = nmiss_q;
    assign w_unused  = ^adr_q[1:0];

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= S_IDLE;
            adr_q   <= 32'd0;
            data_q  <= 32'd0;
            idx_q   <= 5'd0;
            pend_q  <= 1'b0;
            nhit_q  <= '0;
            nmiss_q <= '0;
        end else begin
            nhit_q  <= nhit_d;
            nmiss_q <= nmiss_d;
            case (state_q)
                S_IDLE: begin
                    if (w_flush_go) begin
                        state_q <= S_FLUSH;
                        idx_q   <= 5'd0;
                    end else if (w_miss_det) begin
                        adr_q   <= w_adr;
                        state_q <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (w_flush) pend_q <= 1'b1;
                    if (w_mem_ack) begin
                        data_q  <= w_mem_rdata;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    // A flush requested during the refill runs right after the write.
                    if (w_flush_go) begin
                        pend_q  <= 1'b1;
                        idx_q   <= 5'd0;
                        state_q <= S_FLUSH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    idx_q <= idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        pend_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_cache_refill.sv
`default_nettype none
// Bench for m_cache_refill: a behavioural cache/memory environment with a
// line-level reference model of expected cache contents and counters.
module tb_m_cache_refill;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          w_clk = 1'b0;
    logic          w_rst, w_fetch, w_hit, w_flush, w_mem_ack;
    logic [31:0]   w_adr, w_mem_rdata;
    logic          w_stall, w_mem_req, w_cwe;
    logic [31:0]   w_mem_adr;
    logic [4:0]    w_cwadr;
    logic [57:0]   w_cwd;
    logic [CW-1:0] w_nhit, w_nmiss;

    int checks = 0;
    int failures = 0;

    // expected cache state and counters
    bit          exp_v [32];
    logic [24:0] exp_t [32];
    logic [31:0] exp_d [32];
    int          exp_nhit, exp_nmiss;

    // the cache array itself, written only through the DUT write port
    logic [57:0] cache [32];

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) if (w_cwe) cache[w_cwadr] <= w_cwd;

    assign w_hit = cache[w_adr[6:2]][57] && (cache[w_adr[6:2]][56:32] == w_adr[31:7]);

    m_cache_refill #(.CW(CW)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_adr(w_adr), .w_fetch(w_fetch),
        .w_hit(w_hit), .w_flush(w_flush), .w_stall(w_stall),
        .w_mem_req(w_mem_req), .w_mem_adr(w_mem_adr), .w_mem_ack(w_mem_ack),
        .w_mem_rdata(w_mem_rdata), .w_cwe(w_cwe), .w_cwadr(w_cwadr),
        .w_cwd(w_cwd), .w_nhit(w_nhit), .w_nmiss(w_nmiss)
    );

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic do_reset();
        @(negedge w_clk);
        w_rst = 1'b1; w_fetch = 1'b0; w_flush = 1'b0; w_mem_ack = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
        exp_nhit = 0; exp_nmiss = 0;
    endtask

    // One complete fetch of address a; memory answers k cycles after req rises.
    task automatic fetch_seq(input logic [31:0] a, input int k, input logic [31:0] rd);
        int  idx;
        bit  will_miss, done;
        int  stalls, reqs, writes;
        idx = int'(a[6:2]);
        will_miss = !(exp_v[idx] && exp_t[idx] == a[31:7]);
        done = 0; stalls = 0; reqs = 0; writes = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge w_clk);
            w_fetch = 1'b1; w_adr = a; w_mem_ack = 1'b0; w_mem_rdata = $urandom;
            #1;
            if (!w_stall) begin
                done = 1;
            end else begin
                stalls++;
                if (w_mem_req) begin
                    checks++;
                    if (w_mem_adr !== {a[31:2], 2'b00}) begin
                        failures++;
                        $display("FAIL mem_adr: got %h want %h", w_mem_adr, {a[31:2], 2'b00});
                    end
                    if (reqs == k) begin w_mem_ack = 1'b1; w_mem_rdata = rd; end
                    reqs++;
                end
                if (w_cwe) begin
                    writes++;
                    checks++;
                    if (w_cwadr !== a[6:2] || w_cwd !== {1'b1, a[31:7], rd}) begin
                        failures++;
                        $display("FAIL fill_write: got %0d/%h want %0d/%h",
                                 w_cwadr, w_cwd, a[6:2], {1'b1, a[31:7], rd});
                    end
                end
            end
        end
        checks++;
        if (!done || stalls != (will_miss ? k + 3 : 0) || reqs != (will_miss ? k + 1 : 0)
            || writes != (will_miss ? 1 : 0)) begin
            failures++;
            $display("FAIL fetch_timing adr=%h: got done=%0d stalls=%0d reqs=%0d writes=%0d want stalls=%0d reqs=%0d writes=%0d",
                     a, done, stalls, reqs, writes, will_miss ? k + 3 : 0,
                     will_miss ? k + 1 : 0, will_miss ? 1 : 0);
        end
        if (will_miss) begin
            exp_v[idx] = 1'b1; exp_t[idx] = a[31:7]; exp_d[idx] = rd;
            exp_nmiss = sat_inc(exp_nmiss);
        end
        exp_nhit = sat_inc(exp_nhit);
        checks++;
        if (cache[idx][31:0] !== exp_d[idx]) begin
            failures++;
            $display("FAIL hit_data adr=%h: got %h want %h", a, cache[idx][31:0], exp_d[idx]);
        end
        @(posedge w_clk); #1;
        w_fetch = 1'b0;
        checks++;
        if (int'(w_nhit) != exp_nhit || int'(w_nmiss) != exp_nmiss) begin
            failures++;
            $display("FAIL counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     w_nhit, w_nmiss, exp_nhit, exp_nmiss);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (w_stall !== 1'b0 || w_mem_req !== 1'b0 || w_cwe !== 1'b0
            || w_nhit !== '0 || w_nmiss !== '0) begin
            failures++;
            $display("FAIL reset_state: got stall=%b req=%b cwe=%b hit=%0d miss=%0d want all 0",
                     w_stall, w_mem_req, w_cwe, w_nhit, w_nmiss);
        end
    endtask

    task automatic test_cold_miss();
        fetch_seq(32'h0000_0084, 3, 32'hDEAD_BEEF);
    endtask

    task automatic test_zero_wait();
        fetch_seq(32'h0000_1008, 0, 32'h1234_5678);
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        for (int i = 0; i < 8; i++)
            pool[i] = {25'($urandom), 5'(i % 4 + 8), 2'($urandom)};
        for (int n = 0; n < 30; n++)
            fetch_seq(pool[$urandom_range(0, 7)], $urandom_range(0, 4), $urandom);
    endtask

    task automatic test_flush();
        @(negedge w_clk);
        w_fetch = 1'b0; w_flush = 1'b1;
        #1;
        checks++;
        if (w_stall !== 1'b1 || w_cwe !== 1'b0) begin
            failures++;
            $display("FAIL flush_request: got stall=%b cwe=%b want 1/0", w_stall, w_cwe);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge w_clk);
            w_flush = 1'b0;
            #1;
            checks++;
            if (w_cwe !== 1'b1 || w_cwadr !== 5'(i) || w_cwd !== 58'd0 || w_stall !== 1'b1) begin
                failures++;
                $display("FAIL flush_walk[%0d]: got cwe=%b idx=%0d cwd=%h stall=%b want 1/%0d/0/1",
                         i, w_cwe, w_cwadr, w_cwd, w_stall, i);
            end
        end
        @(negedge w_clk); #1;
        checks++;
        if (w_stall !== 1'b0 || w_cwe !== 1'b0) begin
            failures++;
            $display("FAIL flush_end: got stall=%b cwe=%b want 0/0", w_stall, w_cwe);
        end
        for (int i = 0; i < 32; i++) exp_v[i] = 1'b0;
    endtask

    task automatic test_flush_during_miss();
        logic [31:0] a, rd;
        bit ok;
        a = 32'hCAFE_0050; rd = $urandom; ok = 1;
        @(negedge w_clk); w_fetch = 1'b1; w_adr = a; #1;
        if (w_stall !== 1'b1) ok = 0;
        @(negedge w_clk); w_fetch = 1'b0; #1;
        if (w_mem_req !== 1'b1) ok = 0;
        @(negedge w_clk); w_flush = 1'b1; #1;
        if (w_mem_req !== 1'b1) ok = 0;
        @(negedge w_clk); w_flush = 1'b0; w_mem_ack = 1'b1; w_mem_rdata = rd; #1;
        if (w_mem_req !== 1'b1) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fdm_miss_phase: got ok=%0d want 1", ok);
        end
        @(negedge w_clk); w_mem_ack = 1'b0; #1;
        checks++;
        if (w_cwe !== 1'b1 || w_cwadr !== a[6:2] || w_cwd !== {1'b1, a[31:7], rd}) begin
            failures++;
            $display("FAIL fdm_fill: got cwe=%b idx=%0d cwd=%h want 1/%0d/%h",
                     w_cwe, w_cwadr, w_cwd, a[6:2], {1'b1, a[31:7], rd});
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge w_clk); #1;
            checks++;
            if (w_cwe !== 1'b1 || w_cwadr !== 5'(i) || w_cwd !== 58'd0 || w_stall !== 1'b1) begin
                failures++;
                $display("FAIL fdm_walk[%0d]: got cwe=%b idx=%0d cwd=%h stall=%b want 1/%0d/0/1",
                         i, w_cwe, w_cwadr, w_cwd, w_stall, i);
            end
        end
        @(negedge w_clk); #1;
        exp_nmiss = sat_inc(exp_nmiss);
        for (int i = 0; i < 32; i++) exp_v[i] = 1'b0;
        checks++;
        if (w_stall !== 1'b0 || w_cwe !== 1'b0 || cache[a[6:2]][57] !== 1'b0
            || int'(w_nmiss) != exp_nmiss) begin
            failures++;
            $display("FAIL fdm_end: got stall=%b cwe=%b valid=%b miss=%0d want 0/0/0/%0d",
                     w_stall, w_cwe, cache[a[6:2]][57], w_nmiss, exp_nmiss);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++)
            fetch_seq({25'(i + 100), 5'd20, 2'b00}, 0, $urandom);
        checks++;
        if (int'(w_nhit) != SAT || int'(w_nmiss) != SAT) begin
            failures++;
            $display("FAIL saturation: got hit=%0d miss=%0d want %0d/%0d", w_nhit, w_nmiss, SAT, SAT);
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] a;
        bit ok;
        a = 32'h7700_0028; ok = 1;
        @(negedge w_clk); w_fetch = 1'b1; w_adr = a; #1;
        @(negedge w_clk); w_fetch = 1'b0; #1;
        checks++;
        if (w_mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rmm_req: got %b want 1", w_mem_req);
        end
        @(negedge w_clk); w_rst = 1'b1; #1;
        @(negedge w_clk); w_rst = 1'b0; #1;
        exp_nhit = 0; exp_nmiss = 0;
        checks++;
        if (w_mem_req !== 1'b0 || w_cwe !== 1'b0 || w_stall !== 1'b0
            || w_nhit !== '0 || w_nmiss !== '0) begin
            failures++;
            $display("FAIL rmm_after_reset: got req=%b cwe=%b stall=%b hit=%0d miss=%0d want all 0",
                     w_mem_req, w_cwe, w_stall, w_nhit, w_nmiss);
        end
        w_mem_ack = 1'b1; w_mem_rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge w_clk); w_mem_ack = 1'b0; #1;
            if (w_cwe !== 1'b0 || w_mem_req !== 1'b0) ok = 0;
        end
        checks++;
        if (!ok || cache[a[6:2]][57] !== 1'b0) begin
            failures++;
            $display("FAIL rmm_late_ack: got ok=%0d valid=%b want 1/0", ok, cache[a[6:2]][57]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            cache[i] = 58'd0; exp_v[i] = 1'b0; exp_t[i] = '0; exp_d[i] = '0;
        end
        w_rst = 1'b1; w_fetch = 1'b0; w_flush = 1'b0; w_mem_ack = 1'b0;
        w_adr = 32'd0; w_mem_rdata = 32'd0;
        test_reset();
        test_cold_miss();
        test_zero_wait();
        test_random();
        test_flush();
        test_flush_during_miss();
        test_saturation();
        test_reset_mid_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
